pacman_tile_mover: RTL and testbench

- Sits directly downstream of the direction-latching controller. It consumes the requested direction (`direction_t` from utils) and moves Pac-Man one tile per `move_tick` across the maze grid.
- It queries the maze wall ROM before every step and buffers turns: a requested turn into a wall is held until it becomes legal, and meanwhile motion continues in the current direction.
- Its outputs are the tile position and effective direction, which feed the renderer and the pellet/ghost-collision logic.

---
 rtl/pacman_tile_mover.sv | 159 +++++++++++++++
 tb/tb_pacman_tile_mover.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pacman_tile_mover.sv
// Pac-Man tile mover: steps one maze tile per move_tick. Every step is checked
// against the wall ROM first, and a turn into a wall is held while motion continues.
package utils;
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        UP    = 3'd1,
        DOWN  = 3'd2,
        LEFT  = 3'd3,
        RIGHT = 3'd4
    } direction_t;
endpackage

module pacman_tile_mover
    import utils::*;
#(
    parameter int MAZE_W   = 28,
    parameter int MAZE_H   = 31,
    parameter int START_X  = 13,
    parameter int START_Y  = 23,
    parameter int TUNNEL_Y = 14
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      restart,
    input  direction_t                req_dir,
    input  logic                      move_tick,
    output logic [$clog2(MAZE_W)-1:0] wall_x,
    output logic [$clog2(MAZE_H)-1:0] wall_y,
    output logic                      wall_rd,
    input  logic                      wall_hit,
    output logic [$clog2(MAZE_W)-1:0] pos_x,
    output logic [$clog2(MAZE_H)-1:0] pos_y,
    output direction_t                cur_dir,
    output logic                      moved,
    output logic                      busy,
    output logic [2:0]                dbg_state
);
    localparam int XW = $clog2(MAZE_W);
    localparam int YW = $clog2(MAZE_H);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_QREQ = 3'd1,
        S_WREQ = 3'd2,
        S_QCUR = 3'd3,
        S_WCUR = 3'd4,
        S_STEP = 3'd5
    } state_t;

    state_t          state, next_state;
    direction_t      req_snap;
    direction_t      q_dir;
    logic [XW-1:0]   nb_x;
    logic [YW-1:0]   nb_y;
    logic            nb_ok;
    logic            hit;

    // Neighbour tile in q_dir. The turn path looks at the snapped request, every
    // other state at the current direction; in S_STEP cur_dir already holds the move.
    always_comb begin
        q_dir = (state == S_QREQ || state == S_WREQ) ? req_snap : cur_dir;
        nb_x  = pos_x;
        nb_y  = pos_y;
        nb_ok = 1'b1;
        case (q_dir)
            RIGHT: begin
                if (pos_x == XW'(MAZE_W - 1)) begin
                    if (pos_y == YW'(TUNNEL_Y)) nb_x = '0;
                    else                        nb_ok = 1'b0;
                end else begin
                    nb_x = pos_x + XW'(1);
                end
            end
            LEFT: begin
                if (pos_x == '0) begin
                    if (pos_y == YW'(TUNNEL_Y)) nb_x = XW'(MAZE_W - 1);
                    else                        nb_ok = 1'b0;
                end else begin
                    nb_x = pos_x - XW'(1);
                end
            end
            UP: begin
                if (pos_y == '0) nb_ok = 1'b0;
                else             nb_y = pos_y - YW'(1);
            end
            DOWN: begin
                if (pos_y == YW'(MAZE_H - 1)) nb_ok = 1'b0;
                else                          nb_y = pos_y + YW'(1);
            end
            default: nb_ok = 1'b0;
        endcase
    end

    // An off-grid target never reaches the ROM and is treated as a wall.
    assign hit = wall_hit | ~nb_ok;

    always_comb begin
        next_state = state;
        wall_rd    = 1'b0;
        wall_x     = '0;
        wall_y     = '0;
        moved      = 1'b0;
        case (state)
            S_IDLE: begin
                if (move_tick) begin
                    if (req_dir != IDLE && req_dir != cur_dir) next_state = S_QREQ;
                    else if (cur_dir != IDLE)                  next_state = S_QCUR;
                end
            end
            S_QREQ, S_QCUR: begin
                wall_rd = nb_ok;
                if (nb_ok) begin
                    wall_x = nb_x;
                    wall_y = nb_y;
                end
                next_state = (state == S_QREQ) ? S_WREQ : S_WCUR;
            end
            S_WREQ: begin
                if (!hit)                 next_state = S_STEP;
                else if (cur_dir != IDLE) next_state = S_QCUR;
                else                      next_state = S_IDLE;
            end
            S_WCUR: next_state = hit ? S_IDLE : S_STEP;
            S_STEP: begin
                moved      = 1'b1;
                next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            pos_x    <= XW'(START_X);
            pos_y    <= YW'(START_Y);
            cur_dir  <= IDLE;
            req_snap <= IDLE;
        end else if (restart) begin
            state    <= S_IDLE;
            pos_x    <= XW'(START_X);
            pos_y    <= YW'(START_Y);
            cur_dir  <= IDLE;
            req_snap <= IDLE;
        end else begin
            state <= next_state;
            if (state == S_IDLE && move_tick) req_snap <= req_dir;
            if (state == S_WREQ && !hit)      cur_dir  <= req_snap;
            if (state == S_WCUR && hit)       cur_dir  <= IDLE;
            if (state == S_STEP) begin
                pos_x <= nb_x;
                pos_y <= nb_y;
            end
        end
    end

    assign busy      = (state != S_IDLE);
    assign dbg_state = state;
endmodule

// File: tb/tb_pacman_tile_mover.sv
// Directed bench for pacman_tile_mover: a bench-owned wall map answers ROM
// queries, and every expected query address sits in a scoreboard queue.
module tb_pacman_tile_mover;
    import utils::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       restart = 1'b0;
    direction_t req_dir = IDLE;
    logic       move_tick = 1'b0;
    logic [4:0] wall_x, wall_y, pos_x, pos_y;
    logic       wall_rd, moved, busy;
    logic       wall_hit = 1'b0;
    direction_t cur_dir;
    logic [2:0] dbg_state;

    pacman_tile_mover dut (
        .clk(clk), .reset(reset), .restart(restart), .req_dir(req_dir),
        .move_tick(move_tick), .wall_x(wall_x), .wall_y(wall_y),
        .wall_rd(wall_rd), .wall_hit(wall_hit), .pos_x(pos_x), .pos_y(pos_y),
        .cur_dir(cur_dir), .moved(moved), .busy(busy), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail = 0;
    int q_cnt = 0;
    int moved_cnt = 0;
    int ex, ey, lat, cyc, qc, mc;
    logic walls [0:30][0:27];
    logic [9:0] exp_q[$];

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Synchronous wall ROM: answer one cycle after the strobe.
    always @(posedge clk) wall_hit <= wall_rd ? walls[wall_y][wall_x] : 1'b0;

    // Query scoreboard, entries are {y, x}.
    always @(negedge clk) begin
        if (wall_rd) begin
            q_cnt++;
            if (exp_q.size() == 0) check("extra_query", int'({wall_y, wall_x}), -1);
            else                   check("query_addr", int'({wall_y, wall_x}), int'(exp_q.pop_front()));
        end
        if (moved) moved_cnt++;
    end

    task automatic do_tick(input direction_t d, output int lat_o, output int cyc_o);
        @(negedge clk);
        req_dir   = d;
        move_tick = 1'b1;
        lat_o = 0;
        cyc_o = 0;
        do begin
            @(negedge clk);
            move_tick = 1'b0;
            cyc_o++;
            if (moved) lat_o = cyc_o;
        end while (busy && cyc_o < 20);
        if (busy) check("tick_timeout", 1, 0);
    endtask

    task automatic nav(input direction_t d, input int n, input int dx, input int dy);
        for (int i = 0; i < n; i++) begin
            ex += dx;
            ey += dy;
            exp_q.push_back({ey[4:0], ex[4:0]});
            do_tick(d, lat, cyc);
            check("nav_lat", lat, 3);
            check("nav_x", int'(pos_x), ex);
            check("nav_y", int'(pos_y), ey);
        end
    endtask

    task automatic settle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        for (int y = 0; y < 31; y++)
            for (int x = 0; x < 28; x++) walls[y][x] = 1'b0;
        settle(3);
        check("rst_pos_x", int'(pos_x), 13);
        check("rst_pos_y", int'(pos_y), 23);
        check("rst_dir", int'(cur_dir), int'(IDLE));
        check("rst_busy", int'(busy), 0);
        check("rst_wall_rd", int'(wall_rd), 0);
        check("rst_moved", int'(moved), 0);
        check("rst_wall_xy", int'({wall_y, wall_x}), 0);
        check("rst_state", int'(dbg_state), 0);
        reset = 1'b0;
        settle(2);

        // Idle tick with no direction: nothing happens.
        do_tick(IDLE, lat, cyc);
        settle(3);
        check("idle_pos", int'({pos_y, pos_x}), (23 << 5) | 13);
        check("idle_dir", int'(cur_dir), int'(IDLE));
        check("idle_queries", q_cnt, 0);
        check("idle_moved", moved_cnt, 0);

        // Legal turn from standstill.
        exp_q.push_back({5'd23, 5'd12});
        do_tick(LEFT, lat, cyc);
        check("left_lat", lat, 3);
        check("left_pos", int'({pos_y, pos_x}), (23 << 5) | 12);
        check("left_dir", int'(cur_dir), int'(LEFT));

        // Buffered UP: blocked twice, continues LEFT, then taken.
        walls[22][12] = 1'b1;
        walls[22][11] = 1'b1;
        exp_q.push_back({5'd22, 5'd12});
        exp_q.push_back({5'd23, 5'd11});
        do_tick(UP, lat, cyc);
        check("buf1_lat", lat, 5);
        check("buf1_pos", int'({pos_y, pos_x}), (23 << 5) | 11);
        check("buf1_dir", int'(cur_dir), int'(LEFT));
        exp_q.push_back({5'd22, 5'd11});
        exp_q.push_back({5'd23, 5'd10});
        do_tick(UP, lat, cyc);
        check("buf2_pos", int'({pos_y, pos_x}), (23 << 5) | 10);
        check("buf2_dir", int'(cur_dir), int'(LEFT));
        exp_q.push_back({5'd22, 5'd10});
        do_tick(UP, lat, cyc);
        check("buf3_lat", lat, 3);
        check("buf3_pos", int'({pos_y, pos_x}), (22 << 5) | 10);
        check("buf3_dir", int'(cur_dir), int'(UP));

        // Walk to the tunnel's left end and wrap both ways.
        ex = 10;
        ey = 22;
        nav(UP, 8, 0, -1);
        nav(LEFT, 10, -1, 0);
        exp_q.push_back({5'd14, 5'd27});
        do_tick(LEFT, lat, cyc);
        check("wrapl_lat", lat, 3);
        check("wrapl_pos", int'({pos_y, pos_x}), (14 << 5) | 27);
        exp_q.push_back({5'd14, 5'd0});
        do_tick(RIGHT, lat, cyc);
        check("wrapr_pos", int'({pos_y, pos_x}), (14 << 5) | 0);
        check("wrapr_dir", int'(cur_dir), int'(RIGHT));

        // Left edge off the tunnel row: no ROM query, stop.
        ex = 0;
        ey = 14;
        nav(UP, 9, 0, -1);
        nav(RIGHT, 1, 1, 0);
        nav(LEFT, 1, -1, 0);
        qc = q_cnt;
        mc = moved_cnt;
        do_tick(LEFT, lat, cyc);
        check("edge_queries", q_cnt - qc, 0);
        check("edge_moved", moved_cnt - mc, 0);
        check("edge_dir", int'(cur_dir), int'(IDLE));
        check("edge_pos", int'({pos_y, pos_x}), (5 << 5) | 0);

        // Straight into a wall, with a second tick dropped while busy.
        nav(DOWN, 1, 0, 1);
        walls[7][0] = 1'b1;
        exp_q.push_back({5'd7, 5'd0});
        qc = q_cnt;
        mc = moved_cnt;
        @(negedge clk);
        req_dir   = DOWN;
        move_tick = 1'b1;
        @(negedge clk);
        move_tick = 1'b0;
        @(negedge clk);
        move_tick = 1'b1;
        @(negedge clk);
        move_tick = 1'b0;
        settle(6);
        check("wall_queries", q_cnt - qc, 1);
        check("wall_moved", moved_cnt - mc, 0);
        check("wall_dir", int'(cur_dir), int'(IDLE));
        check("wall_pos", int'({pos_y, pos_x}), (6 << 5) | 0);
        check("wall_busy", int'(busy), 0);

        // Blocked request from standstill stays put.
        exp_q.push_back({5'd7, 5'd0});
        do_tick(DOWN, lat, cyc);
        check("blk_lat", lat, 0);
        check("blk_pos", int'({pos_y, pos_x}), (6 << 5) | 0);
        check("blk_dir", int'(cur_dir), int'(IDLE));

        // Async reset while waiting on a free-tile answer.
        exp_q.push_back({5'd6, 5'd1});
        mc = moved_cnt;
        @(negedge clk);
        req_dir   = RIGHT;
        move_tick = 1'b1;
        @(negedge clk);
        move_tick = 1'b0;
        @(negedge clk);
        check("rstq_state", int'(dbg_state), 2);
        reset = 1'b1;
        #1;
        check("rstq_pos_async", int'({pos_y, pos_x}), (23 << 5) | 13);
        @(negedge clk);
        reset = 1'b0;
        settle(5);
        check("rstq_moved", moved_cnt - mc, 0);
        check("rstq_pos", int'({pos_y, pos_x}), (23 << 5) | 13);
        check("rstq_dir", int'(cur_dir), int'(IDLE));
        check("rstq_state_idle", int'(dbg_state), 0);

        // Synchronous restart at the same point.
        ex = 13;
        ey = 23;
        nav(LEFT, 1, -1, 0);
        exp_q.push_back({5'd24, 5'd12});
        mc = moved_cnt;
        @(negedge clk);
        req_dir   = DOWN;
        move_tick = 1'b1;
        @(negedge clk);
        move_tick = 1'b0;
        @(negedge clk);
        check("rsq_state", int'(dbg_state), 2);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        check("rsq_pos", int'({pos_y, pos_x}), (23 << 5) | 13);
        settle(5);
        check("rsq_moved", moved_cnt - mc, 0);
        check("rsq_pos_hold", int'({pos_y, pos_x}), (23 << 5) | 13);
        check("rsq_dir", int'(cur_dir), int'(IDLE));
        check("rsq_busy", int'(busy), 0);

        check("queries_left", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
